// File: rtl/md_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package md_pkg;

  localparam int MD_WIDTH = 32;
  // Shift steps per operation; one extra FIX cycle follows them.
  localparam int MD_STEPS = MD_WIDTH;

  // Encoding matches the 2-bit op port: bit 1 selects divide, bit 0 selects signed.
  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_t;

endpackage

// File: rtl/md_step.sv
// One iteration of the sequencer: a shift-add multiply step or a restoring
// shift-subtract divide step, operating on unsigned magnitudes.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,       // product high half / partial remainder
  input  logic [WIDTH-1:0] lo_w,      // multiplier bits / dividend-quotient bits
  input  logic [WIDTH-1:0] operand,   // multiplicand / divisor
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] lo_w_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           fits;

  // Compute both step flavours and select by operation type.
  always_comb begin
    // NOTE: every output gets a value on every path, otherwise always_comb infers a latch.
    acc_nxt  = '0;
    lo_w_nxt = '0;

    // Multiply: conditionally add, then shift {carry,acc,lo_w} right by one.
    sum = lo_w[0] ? ({1'b0, acc} + {1'b0, operand}) : {1'b0, acc};

    // Divide: the remainder is kept one bit wider after the shift so that
    // divisors with the top bit set still compare correctly.
    rem_sh = {acc, lo_w[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, operand});
    diff   = rem_sh - {1'b0, operand};

    if (is_div) begin
      if (fits) begin
        acc_nxt  = WIDTH'(diff);
        lo_w_nxt = {lo_w[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt  = WIDTH'(rem_sh);
        lo_w_nxt = {lo_w[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt  = sum[WIDTH:1];
      lo_w_nxt = {sum[0], lo_w[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer writing HI/LO. Fixed latency:
// WIDTH step cycles plus one sign-fix cycle, then a one-cycle done pulse.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t        state, state_nxt;
  md_op_t           op_q;
  logic             sign_a, sign_b, b_zero;
  logic [WIDTH-1:0] a_raw, acc, lo_w, operand;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_nxt, lo_w_nxt;

  logic             accept, last_step;
  logic             neg_a_in, neg_b_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, hi_fix, lo_fix;
  logic               dbz_fix;

  // A new request is taken in IDLE and also in DONE, giving back-to-back issue.
  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (count == CNT_W'(WIDTH - 1));

  // Operand magnitudes: abs() for signed ops, raw bits for unsigned ops.
  always_comb begin
    neg_a_in = op[0] & in_a[WIDTH-1];
    neg_b_in = op[0] & in_b[WIDTH-1];
    mag_a    = neg_a_in ? -in_a : in_a;
    mag_b    = neg_b_in ? -in_b : in_b;
  end

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_q[1]),
    .acc      (acc),
    .lo_w     (lo_w),
    .operand  (operand),
    .acc_nxt  (acc_nxt),
    .lo_w_nxt (lo_w_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
  end

  // Sign correction and divide-by-zero substitution, consumed in FIX.
  always_comb begin
    prod     = {acc, lo_w};
    prod_fix = (op_q == MULT && (sign_a ^ sign_b)) ? -prod : prod;
    q_fix    = (op_q == DIV && (sign_a ^ sign_b)) ? -lo_w : lo_w;
    r_fix    = (op_q == DIV && sign_a) ? -acc : acc;
    if (!op_q[1]) begin
      hi_fix  = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix  = prod_fix[WIDTH-1:0];
      dbz_fix = 1'b0;
    end else if (b_zero) begin
      hi_fix  = a_raw;
      lo_fix  = '1;
      dbz_fix = 1'b1;
    end else begin
      hi_fix  = r_fix;
      lo_fix  = q_fix;
      dbz_fix = 1'b0;
    end
  end

  // Datapath: latch on accept, iterate in CALC, publish results in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: reset clears every working register so an aborted operation leaves nothing behind.
    if (!rst_n) begin
      op_q        <= MULTU;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      a_raw       <= '0;
      acc         <= '0;
      lo_w        <= '0;
      operand     <= '0;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_q    <= md_op_t'(op);
      sign_a  <= neg_a_in;
      sign_b  <= neg_b_in;
      b_zero  <= (in_b == '0);
      a_raw   <= in_a;
      acc     <= '0;
      // Multiply shifts the multiplier through lo_w; divide shifts the dividend.
      lo_w    <= op[1] ? mag_a : mag_b;
      operand <= op[1] ? mag_b : mag_a;
      count   <= '0;
    end else if (state == CALC) begin
      acc   <= acc_nxt;
      lo_w  <= lo_w_nxt;
      count <= count + 1'b1;
    end else if (state == FIX) begin
      hi          <= hi_fix;
      lo          <= lo_fix;
      div_by_zero <= dbz_fix;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes hand-computed results,
// a monitor pops and compares them whenever done is seen.
module tb_mult_div_unit;
  import md_pkg::*;

  localparam int LAT = MD_STEPS + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] in_a = '0, in_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          k;
  } exp_t;

  typedef struct {
    string       name;
    md_op_t      o;
    logic [31:0] a, b, eh, el;
    logic        ed;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   busy_run = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .in_a        (in_a),
    .in_b        (in_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare each completion against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "/hi"}, hi, mon_e.hi);
        check({mon_e.name, "/lo"}, lo, mon_e.lo);
        check({mon_e.name, "/dbz"}, 32'(div_by_zero), 32'(mon_e.dbz));
        check({mon_e.name, "/latency"}, 32'(cyc - mon_e.k), 32'(LAT));
        check({mon_e.name, "/busy_cycles"}, 32'(busy_run), 32'(LAT));
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Drive one request for a single edge; optionally record its expected result.
  task automatic issue(input vec_t v, input bit expect_it);
    @(negedge clk);
    start = 1'b1;
    op    = v.o;
    in_a  = v.a;
    in_b  = v.b;
    if (expect_it) sb.push_back(exp_t'{v.name, v.eh, v.el, v.ed, cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been seen, then idle a little.
  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check("completion_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs[11] = '{
    '{"multu_max",   MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0},
    '{"mult_neg",    MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0},
    '{"mult_minsq",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0},
    '{"divu_100_7",  DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0},
    '{"div_m7_2",    DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
    '{"div_7_m2",    DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0},
    '{"div_ovf",     DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0},
    '{"divu_bigdiv", DIVU,  32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001, 1'b0},
    '{"divu_by0",    DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1},
    '{"div_by0",     DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1},
    '{"multu_2_3",   MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0}
  };

  vec_t v_first  = '{"ign_first",  MULT,  32'h00001234, 32'h00000010, 32'h00000000, 32'h00012340, 1'b0};
  vec_t v_intr   = '{"ign_intr",   DIVU,  32'd9,        32'd3,        32'd0,        32'd3,        1'b0};
  vec_t v_b2b_a  = '{"b2b_a",      DIVU,  32'd1000,     32'd10,       32'd0,        32'd100,      1'b0};
  vec_t v_b2b_b  = '{"b2b_b",      MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
  vec_t v_abort  = '{"aborted",    DIVU,  32'd1000,     32'd3,        32'd1,        32'd333,      1'b0};
  vec_t v_after  = '{"after_rst",  MULTU, 32'd7,        32'd6,        32'd0,        32'd42,       1'b0};

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst/hi", hi, 32'd0);
    check("rst/lo", lo, 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors, one at a time.
    foreach (vecs[i]) begin
      issue(vecs[i], 1'b1);
      wait_idle();
    end

    // A start pulse mid-operation must be ignored.
    issue(v_first, 1'b1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    op    = v_intr.o;
    in_a  = v_intr.a;
    in_b  = v_intr.b;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held during the done cycle: second op begins with no bubble.
    issue(v_b2b_a, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b/done_seen", 32'(done), 32'd1);
    start = 1'b1;
    op    = v_b2b_b.o;
    in_a  = v_b2b_b.a;
    in_b  = v_b2b_b.b;
    sb.push_back(exp_t'{v_b2b_b.name, v_b2b_b.eh, v_b2b_b.el, v_b2b_b.ed, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    check("b2b/busy_next", 32'(busy), 32'd1);
    wait_idle();

    // Reset in the middle of a divide aborts it with no done pulse.
    issue(v_abort, 1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort/hi", hi, 32'd0);
    check("abort/lo", lo, 32'd0);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort/lo_held", lo, 32'd0);
    issue(v_after, 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide sequencer sitting beside the single-cycle ALU. It serves MULT, MULTU, DIV and DIVU, writing results to HI/LO.
- Runs one shift-add or shift-subtract step per clock over 32 iterations, followed by one sign-fix cycle.
- Exposes busy/done so the control unit can stall the pipeline until HI/LO are valid.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH each, iteration count = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when idle or in the done cycle
- op  in  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV (signed = two's complement)
- in_a  in  WIDTH  multiplicand / dividend
- in_b  in  WIDTH  multiplier / divisor
- busy  out  1  high in CALC and FIX states
- done  out  1  one-cycle pulse when hi/lo are updated
- hi  out  WIDTH  product[63:32] / remainder
- lo  out  WIDTH  product[31:0] / quotient
- div_by_zero  out  1  registered with done; high when a divide had in_b == 0; holds until the next completion

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; counter and working registers cleared.
  - A reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: on start=1, latch op, latch the sign of in_a and in_b, and latch the magnitudes. Magnitudes are abs() for signed ops and raw for unsigned ops. Set count=0 and go to CALC.
  - CALC: perform one step per edge and increment count. Move to FIX on the edge that performs step WIDTH-1 (count==WIDTH-1).
  - FIX: apply the sign correction, register the results into hi/lo/div_by_zero, and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation with no bubble).
- Latency:
  - start sampled at edge k; steps occur at edges k+1..k+32; FIX at edge k+33.
  - done is high during the cycle following edge k+33, so there is a fixed 33-cycle latency for every op.
- start while busy is ignored; no queueing.
- Multiply step (unsigned magnitudes), with P={acc,lo_w}, acc=0 and lo_w=multiplier at start:
  - If lo_w[0]=1, sum = {1'b0,acc} + {1'b0,mcand} (WIDTH+1 bits); else sum = {1'b0,acc}.
  - Then {acc,lo_w} = {sum,lo_w[WIDTH-1:1]}, which is the 2*WIDTH+1-bit right shift.
- Divide step (restoring), with rem=0 and q=dividend at start:
  - {rem,q} <<= 1.
  - trial = {1'b0,rem} - {1'b0,divisor}.
  - If trial[WIDTH]==0 then rem = trial[WIDTH-1:0] and q[0]=1; else q[0]=0.
- FIX rules:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / -1 gives lo=0x80000000, hi=0 (wrap, no flag).
- Divide by zero (DIVU or DIV with in_b==0):
  - hi = original in_a (unmodified by sign logic), lo = all ones, div_by_zero=1.
  - Latency is unchanged (33 cycles).
- hi/lo hold their previous values throughout CALC/FIX and change only at the FIX→DONE edge. They hold until the next completion.
- Multiply ops always drive div_by_zero=0 on completion.

Decomposition:
- Package md_pkg:
  - md_op_t enum (MULTU, MULT, DIVU, DIV).
  - md_state_t enum (IDLE, CALC, FIX, DONE).
  - Constant MD_STEPS = WIDTH.
- One sub-module, md_step: purely combinational single iteration.
  - Inputs: is_div, acc/rem, lo_w/q, operand.
  - Outputs: next acc/rem and next lo_w/q.
  - Instanced once inside mult_div_unit.
- Counter, FSM and sign fix live in mult_div_unit.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001, busy high for the 33 cycles before done.
- MULT −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIVU 100/7 → lo=14, hi=2; DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIVU 5/0 and DIV −5/0 → lo=0xFFFFFFFF, hi=in_a, div_by_zero=1; a following MULTU 2×3 → hi=0, lo=6, div_by_zero=0.
- start pulsed at cycle 10 of an op with different operands → ignored, first result unaffected. start held in the DONE cycle → second op begins with no idle cycle; its done follows 33 cycles later.
- rst_n low at step 15 of a divide → immediate IDLE; hi=lo=0, no done pulse; a new op after release completes normally.
